// File: rtl/pipe_ctrl_seq.sv
// Stage-2 pipeline controller: instruction register, stack pointer and RUN/HALT sequencing.
// Optional STACK_CHECK_EN adds sticky stack_err and suppresses overflowing/underflowing stack ops.
module pipe_ctrl_seq #(
    parameter int              IW      = 16,
    parameter int              SPW     = 8,
    parameter logic [SPW-1:0]  SP_INIT = {SPW{1'b1}}
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [IW-1:0]  instr_in,
    input  logic           instr_valid,
    input  logic           p_Z,
    input  logic [SPW-1:0] sp_load_data,
    output logic [IW-1:0]  ir2,
    output logic           v2,
    output logic           alu_write_en,
    output logic           regw_en,
    output logic           datar_en,
    output logic           dataw_en,
    output logic           pc_load_en,
    output logic           stack_push,
    output logic           stack_pop,
    output logic [SPW-1:0] stack_addr,
    output logic [SPW-1:0] sp,
    output logic           flush,
`ifdef STACK_CHECK_EN
    output logic           stack_err,
`endif
    output logic           halted
);

    typedef enum logic {RUN, HALT} state_t;

    state_t         state, next_state;
    logic [2:0]     opc, func;
    logic [1:0]     sub;
    logic           is_alu, is_mov, is_load, is_store, is_jz, is_jnz, is_cz, is_cnz;
    logic           is_sys, is_ldsp, is_retz, is_retnz, is_hlt;
    logic           g, cond, call_req, ret_req, ovf, unf;
    logic [SPW-1:0] sp_inc, sp_next;

    always_comb begin
        opc      = ir2[IW-1:IW-3];
        func     = ir2[2:0];
        sub      = ir2[IW-4:IW-5];
        is_alu   = (opc == 3'b000) | ((opc == 3'b001) & ~func[2]);
        is_mov   = (opc == 3'b001) & (func == 3'b100);
        is_sys   = (opc == 3'b001) & (func == 3'b101);
        is_load  = (opc == 3'b010);
        is_store = (opc == 3'b011);
        is_jz    = (opc == 3'b100);
        is_jnz   = (opc == 3'b101);
        is_cz    = (opc == 3'b110);
        is_cnz   = (opc == 3'b111);
        is_ldsp  = is_sys & (sub == 2'b00);
        is_retz  = is_sys & (sub == 2'b01);
        is_retnz = is_sys & (sub == 2'b10);
        is_hlt   = is_sys & (sub == 2'b11);
    end

    assign g        = v2 & (state == RUN);
    assign cond     = (is_jz | is_cz | is_retz) ? p_Z : ~p_Z;
    assign call_req = g & (is_cz | is_cnz) & cond;
    assign ret_req  = g & (is_retz | is_retnz) & cond;
    assign sp_inc   = sp + SPW'(1);

`ifdef STACK_CHECK_EN
    assign ovf = call_req & (sp == '0);
    assign unf = ret_req & (sp == SP_INIT);
`else
    assign ovf = 1'b0;
    assign unf = 1'b0;
`endif

    always_comb begin
        next_state   = state;
        alu_write_en = g & is_alu;
        regw_en      = g & (is_alu | is_mov | is_load);
        stack_push   = call_req & ~ovf;
        stack_pop    = ret_req & ~unf;
        dataw_en     = (g & is_store) | stack_push;
        datar_en     = (g & is_load) | stack_pop;
        pc_load_en   = (g & (is_jz | is_jnz) & cond) | stack_push | stack_pop;
        flush        = pc_load_en | (g & is_hlt);
        stack_addr   = stack_push ? sp : sp_inc;
        sp_next      = sp;
        if (stack_push)
            sp_next = sp - SPW'(1);
        else if (stack_pop)
            sp_next = sp_inc;
        else if (g & is_ldsp)
            sp_next = sp_load_data;
        if (g & is_hlt)
            next_state = HALT;
    end

    // v2 is cleared on entry to HALT so the instruction behind HLT never becomes valid.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= RUN;
            sp    <= SP_INIT;
            ir2   <= '0;
            v2    <= 1'b0;
        end else begin
            state <= next_state;
            sp    <= sp_next;
            ir2   <= instr_in;
            v2    <= instr_valid & ~flush & (next_state == RUN);
        end
    end

`ifdef STACK_CHECK_EN
    always_ff @(posedge clk) begin
        if (reset)
            stack_err <= 1'b0;
        else if (ovf | unf)
            stack_err <= 1'b1;
    end
`endif

    assign halted = (state == HALT);

endmodule

// File: tb/tb_pipe_ctrl_seq.sv
// Scoreboard bench for pipe_ctrl_seq: stimulus pushes expected per-cycle outputs, monitor pops at negedge.
// Honours STACK_CHECK_EN when defined for both DUT and bench.
module tb_pipe_ctrl_seq;

`ifdef STACK_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] instr_in;
    logic        instr_valid;
    logic        p_Z;
    logic [7:0]  sp_load_data;
    logic [15:0] ir2;
    logic        v2, alu_write_en, regw_en, datar_en, dataw_en, pc_load_en;
    logic        stack_push, stack_pop, flush, halted;
    logic [7:0]  stack_addr, sp;
    logic        err_act;

    always #5 clk = ~clk;

    pipe_ctrl_seq dut (
        .clk(clk), .reset(reset), .instr_in(instr_in), .instr_valid(instr_valid),
        .p_Z(p_Z), .sp_load_data(sp_load_data), .ir2(ir2), .v2(v2),
        .alu_write_en(alu_write_en), .regw_en(regw_en), .datar_en(datar_en),
        .dataw_en(dataw_en), .pc_load_en(pc_load_en), .stack_push(stack_push),
        .stack_pop(stack_pop), .stack_addr(stack_addr), .sp(sp), .flush(flush),
`ifdef STACK_CHECK_EN
        .stack_err(err_act),
`endif
        .halted(halted)
    );

`ifndef STACK_CHECK_EN
    assign err_act = 1'b0;
`endif

    typedef struct packed {
        logic [15:0] ir2;
        logic        v2, alu, regw, datar, dataw, pcl, push, pop;
        logic [7:0]  addr, sp;
        logic        flush, halted, err;
    } exp_t;

    exp_t        sb[$];
    int          n_vec = 0;
    int          n_err = 0;
    bit          stim_done = 1'b0;

    // reference state: what stage 2 holds and the architectural stack pointer
    logic [15:0] m_ir2;
    logic        m_v2, m_halt, m_err;
    logic [7:0]  m_sp;

    function automatic logic [15:0] mk(input logic [2:0] op, input logic [1:0] so, input logic [2:0] fn);
        logic [7:0] mid;
        mid = 8'($urandom);
        return {op, so, mid, fn};
    endfunction

    function automatic logic [15:0] rand_instr();
        logic [2:0] op, fn;
        op = 3'($urandom_range(0, 7));
        fn = 3'($urandom);
        if (op == 3'b001 && $urandom_range(0, 1) == 1) fn = 3'b101;
        return mk(op, 2'($urandom), fn);
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic step(input logic r, input logic [15:0] ins, input logic vld,
                        input logic z, input logic [7:0] ld);
        exp_t       e;
        logic [2:0] op, fn;
        logic [1:0] so;
        logic       g, ztype, taken, call, ret, hlt, ldsp, errset, hnext;
        reset = r; instr_in = ins; instr_valid = vld; p_Z = z; sp_load_data = ld;
        op = m_ir2[15:13]; fn = m_ir2[2:0]; so = m_ir2[12:11];
        g = m_v2 && !m_halt;
        e = '0;
        e.ir2 = m_ir2; e.v2 = m_v2; e.sp = m_sp; e.addr = m_sp + 8'd1;
        e.halted = m_halt; e.err = m_err;
        ztype = 1'b0; call = 1'b0; ret = 1'b0; hlt = 1'b0; ldsp = 1'b0; errset = 1'b0;
        if (g) begin
            case (op)
                3'd0: begin e.alu = 1'b1; e.regw = 1'b1; end
                3'd1: begin
                    if (!fn[2]) begin e.alu = 1'b1; e.regw = 1'b1; end
                    else if (fn == 3'b100) e.regw = 1'b1;
                    else if (fn == 3'b101) begin
                        case (so)
                            2'd0: ldsp = 1'b1;
                            2'd1: begin ret = 1'b1; ztype = 1'b1; end
                            2'd2: ret = 1'b1;
                            default: hlt = 1'b1;
                        endcase
                    end
                end
                3'd2: begin e.regw = 1'b1; e.datar = 1'b1; end
                3'd3: e.dataw = 1'b1;
                3'd4, 3'd5: begin
                    ztype = (op == 3'd4);
                    if (ztype ? z : !z) begin e.pcl = 1'b1; e.flush = 1'b1; end
                end
                default: begin call = 1'b1; ztype = (op == 3'd6); end
            endcase
        end
        taken = ztype ? z : !z;
        if (call && taken) begin
            if (CHK && m_sp == 8'h00) errset = 1'b1;
            else begin
                e.push = 1'b1; e.dataw = 1'b1; e.pcl = 1'b1; e.flush = 1'b1; e.addr = m_sp;
            end
        end
        if (ret && taken) begin
            if (CHK && m_sp == 8'hFF) errset = 1'b1;
            else begin e.pop = 1'b1; e.datar = 1'b1; e.pcl = 1'b1; e.flush = 1'b1; end
        end
        if (hlt) e.flush = 1'b1;
        sb.push_back(e);
        if (r) begin
            m_ir2 = '0; m_v2 = 1'b0; m_halt = 1'b0; m_err = 1'b0; m_sp = 8'hFF;
        end else begin
            hnext  = m_halt | hlt;
            if (e.push) m_sp = m_sp - 8'd1;
            else if (e.pop) m_sp = m_sp + 8'd1;
            else if (ldsp) m_sp = ld;
            m_v2   = vld & !e.flush & !hnext;
            m_halt = hnext;
            m_ir2  = ins;
            m_err  = m_err | errset;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                n_vec++;
                chk("ir2", ir2, e.ir2);
                chk("v2", 16'(v2), 16'(e.v2));
                chk("alu_write_en", 16'(alu_write_en), 16'(e.alu));
                chk("regw_en", 16'(regw_en), 16'(e.regw));
                chk("datar_en", 16'(datar_en), 16'(e.datar));
                chk("dataw_en", 16'(dataw_en), 16'(e.dataw));
                chk("pc_load_en", 16'(pc_load_en), 16'(e.pcl));
                chk("stack_push", 16'(stack_push), 16'(e.push));
                chk("stack_pop", 16'(stack_pop), 16'(e.pop));
                chk("stack_addr", 16'(stack_addr), 16'(e.addr));
                chk("sp", 16'(sp), 16'(e.sp));
                chk("flush", 16'(flush), 16'(e.flush));
                chk("halted", 16'(halted), 16'(e.halted));
                chk("stack_err", 16'(err_act), 16'(e.err));
            end
        end
    end

    initial begin : stim
        logic [15:0] alu_i, cz_i, cnz_i, ldsp_i, retz_i, retnz_i, hlt_i;
        logic [7:0]  ld;
        reset = 1'b1; instr_in = '0; instr_valid = 1'b0; p_Z = 1'b0; sp_load_data = '0;
        repeat (2) @(posedge clk);
        #1;
        m_ir2 = '0; m_v2 = 1'b0; m_halt = 1'b0; m_err = 1'b0; m_sp = 8'hFF;
        alu_i   = mk(3'b000, 2'b00, 3'b000);
        cz_i    = mk(3'b110, 2'b00, 3'b000);
        cnz_i   = mk(3'b111, 2'b00, 3'b000);
        ldsp_i  = mk(3'b001, 2'b00, 3'b101);
        retz_i  = mk(3'b001, 2'b01, 3'b101);
        retnz_i = mk(3'b001, 2'b10, 3'b101);
        hlt_i   = mk(3'b001, 2'b11, 3'b101);

        step(1'b0, cz_i,    1'b1, 1'b0, 8'h00);
        step(1'b0, alu_i,   1'b1, 1'b1, 8'h00);   // taken CZ at sp=FF
        step(1'b0, cnz_i,   1'b1, 1'b1, 8'h00);   // squashed slot
        step(1'b0, alu_i,   1'b1, 1'b1, 8'h00);   // CNZ not taken
        step(1'b0, ldsp_i,  1'b1, 1'b0, 8'h10);
        step(1'b0, retnz_i, 1'b1, 1'b0, 8'h10);   // LDSP in stage 2
        step(1'b0, alu_i,   1'b1, 1'b0, 8'h10);   // RETNZ taken, pops from 0x11
        step(1'b0, hlt_i,   1'b1, 1'b0, 8'h00);
        step(1'b0, alu_i,   1'b1, 1'b0, 8'h00);   // HLT in stage 2
        for (int i = 0; i < 11; i++) step(1'b0, rand_instr(), 1'b1, 1'($urandom), 8'($urandom));
        step(1'b1, alu_i,   1'b1, 1'b0, 8'h00);
        step(1'b0, retz_i,  1'b1, 1'b1, 8'h00);
        step(1'b0, alu_i,   1'b1, 1'b1, 8'h00);   // RETZ at empty stack
        step(1'b0, alu_i,   1'b1, 1'b1, 8'h00);
        step(1'b1, alu_i,   1'b0, 1'b0, 8'h00);
        step(1'b0, cz_i,    1'b1, 1'b1, 8'h00);
        step(1'b1, alu_i,   1'b1, 1'b1, 8'h00);   // reset with taken CZ in stage 2
        step(1'b0, alu_i,   1'b1, 1'b1, 8'h00);
        step(1'b0, alu_i,   1'b1, 1'b1, 8'h00);

        for (int i = 0; i < 4000; i++) begin
            case ($urandom_range(0, 3))
                0: ld = 8'h00;
                1: ld = 8'hFF;
                default: ld = 8'($urandom);
            endcase
            step(($urandom_range(0, 63) == 0), rand_instr(), ($urandom_range(0, 9) != 0),
                 1'($urandom), ld);
        end
        stim_done = 1'b1;
        repeat (2) @(negedge clk);
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
